// File: rtl/fc_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM state encoding
// and the signed 16-bit saturation limits applied to neuron results.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } fc_state_e;

  localparam int signed SAT_MAX = 32'sd32767;
  localparam int signed SAT_MIN = -32'sd32768;

endpackage

// File: rtl/fc_result_sat.sv
// Post-processing for one neuron result: optional ReLU, then clamp to signed 16 bits.
module fc_result_sat
  import fc_seq_pkg::*;
#(
  parameter int RWIDTH = 32
) (
  input  logic [RWIDTH-1:0] din,
  input  logic              relu_en,
  output logic [15:0]       dout
);

  localparam logic signed [RWIDTH-1:0] MAX_R = RWIDTH'(SAT_MAX);
  localparam logic signed [RWIDTH-1:0] MIN_R = RWIDTH'(SAT_MIN);

  logic signed [RWIDTH-1:0] val_s;

  // ReLU clamp of negative values, followed by signed 16-bit saturation
  always_comb begin
    val_s = $signed(din);
    dout  = 16'h0000;
    if (relu_en && din[RWIDTH-1]) begin
      val_s = '0;
    end else begin
      val_s = $signed(din);
    end
    if (val_s > MAX_R) begin
      dout = 16'h7FFF;
    end else if (val_s < MIN_R) begin
      dout = 16'h8000;
    end else begin
      dout = val_s[15:0];
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer: launches the data mover per neuron pair,
// post-processes the two results and writes them packed into the result BRAM.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int CNT_BIT = 31,
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int RWIDTH  = 32,
  parameter int TMO_BIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic [AWIDTH-1:0]  i_num_grp,
  input  logic               i_relu_en,
  input  logic [TMO_BIT-1:0] i_timeout,
  input  logic               i_err_clr,
  output logic               o_idle,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [AWIDTH-1:0]  o_grp_idx,
  output logic               o_mv_run,
  output logic [CNT_BIT-1:0] o_mv_num_cnt,
  output logic [AWIDTH-1:0]  o_mv_base,
  input  logic               i_mv_idle,
  input  logic               i_mv_done,
  input  logic [RWIDTH-1:0]  i_result_0,
  input  logic [RWIDTH-1:0]  i_result_1,
  output logic [AWIDTH-1:0]  addr_o,
  output logic               ce_o,
  output logic               we_o,
  output logic [DWIDTH-1:0]  d_o
);

  fc_state_e          state_r;
  logic [CNT_BIT-1:0] num_cnt_r;
  logic [AWIDTH-1:0]  num_grp_r;
  logic               relu_en_r;
  logic [TMO_BIT-1:0] timeout_r;
  logic [TMO_BIT-1:0] timer_r;
  logic [AWIDTH-1:0]  grp_idx_r;
  logic [AWIDTH-1:0]  base_r;
  logic [RWIDTH-1:0]  res0_r;
  logic [RWIDTH-1:0]  res1_r;
  logic               mv_run_r;
  logic               done_r;
  logic               ce_r;
  logic               we_r;
  logic [AWIDTH-1:0]  addr_r;
  logic [DWIDTH-1:0]  data_r;
  logic [15:0]        sat0_s;
  logic [15:0]        sat1_s;

  fc_result_sat #(.RWIDTH(RWIDTH)) u_sat0 (
    .din     (res0_r),
    .relu_en (relu_en_r),
    .dout    (sat0_s)
  );

  fc_result_sat #(.RWIDTH(RWIDTH)) u_sat1 (
    .din     (res1_r),
    .relu_en (relu_en_r),
    .dout    (sat1_s)
  );

  // Layer FSM; strobes are registered on entry to the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      num_cnt_r <= '0;
      num_grp_r <= '0;
      relu_en_r <= 1'b0;
      timeout_r <= '0;
      timer_r   <= '0;
      grp_idx_r <= '0;
      base_r    <= '0;
      res0_r    <= '0;
      res1_r    <= '0;
      mv_run_r  <= 1'b0;
      done_r    <= 1'b0;
      ce_r      <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
    end else begin
      mv_run_r <= 1'b0;
      done_r   <= 1'b0;
      ce_r     <= 1'b0;
      we_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            num_cnt_r <= i_num_cnt;
            num_grp_r <= i_num_grp;
            relu_en_r <= i_relu_en;
            timeout_r <= i_timeout;
            grp_idx_r <= '0;
            base_r    <= '0;
            state_r   <= ST_LAUNCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          // An empty layer completes without touching the mover or the BRAM
          if ((num_cnt_r == '0) || (num_grp_r == '0)) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (i_mv_idle) begin
            mv_run_r <= 1'b1;
            timer_r  <= '0;
            state_r  <= ST_WAIT;
          end else begin
            state_r <= ST_LAUNCH;
          end
        end
        ST_WAIT: begin
          if (i_mv_done) begin
            res0_r  <= i_result_0;
            res1_r  <= i_result_1;
            state_r <= ST_CAPTURE;
          end else if ((timeout_r != '0) && (timer_r == timeout_r)) begin
            state_r <= ST_ERR;
          end else begin
            timer_r <= timer_r + TMO_BIT'(1);
          end
        end
        ST_CAPTURE: begin
          addr_r  <= grp_idx_r;
          data_r  <= DWIDTH'({sat0_s, sat1_s});
          ce_r    <= 1'b1;
          we_r    <= 1'b1;
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          if (grp_idx_r == (num_grp_r - AWIDTH'(1))) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            // Running sum replaces grp_idx * num_cnt
            grp_idx_r <= grp_idx_r + AWIDTH'(1);
            base_r    <= base_r + num_cnt_r[AWIDTH-1:0];
            state_r   <= ST_LAUNCH;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          if (i_err_clr) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ERR;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_idle       = (state_r == ST_IDLE);
  assign o_busy       = (state_r != ST_IDLE) && (state_r != ST_ERR);
  assign o_error      = (state_r == ST_ERR);
  assign o_done       = done_r;
  assign o_grp_idx    = grp_idx_r;
  assign o_mv_run     = mv_run_r;
  assign o_mv_num_cnt = num_cnt_r;
  assign o_mv_base    = base_r;
  assign addr_o       = addr_r;
  assign ce_o         = ce_r;
  assign we_o         = we_r;
  assign d_o          = data_r;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: a scoreboard of expected runs, writes and done
// pulses derived from each layer's configuration, plus literal spot checks.
module tb_fc_layer_sequencer;

  localparam int CNT_BIT = 31;
  localparam int AWIDTH  = 12;
  localparam int DWIDTH  = 32;
  localparam int RWIDTH  = 32;
  localparam int TMO_BIT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_start;
  logic [CNT_BIT-1:0] i_num_cnt;
  logic [AWIDTH-1:0]  i_num_grp;
  logic               i_relu_en;
  logic [TMO_BIT-1:0] i_timeout;
  logic               i_err_clr;
  logic               o_idle, o_busy, o_done, o_error;
  logic [AWIDTH-1:0]  o_grp_idx;
  logic               o_mv_run;
  logic [CNT_BIT-1:0] o_mv_num_cnt;
  logic [AWIDTH-1:0]  o_mv_base;
  logic               i_mv_idle;
  logic               i_mv_done;
  logic [RWIDTH-1:0]  i_result_0, i_result_1;
  logic [AWIDTH-1:0]  addr_o;
  logic               ce_o, we_o;
  logic [DWIDTH-1:0]  d_o;

  always #5 clk = ~clk;

  fc_layer_sequencer #(
    .CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RWIDTH(RWIDTH), .TMO_BIT(TMO_BIT)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_cnt(i_num_cnt),
    .i_num_grp(i_num_grp), .i_relu_en(i_relu_en), .i_timeout(i_timeout),
    .i_err_clr(i_err_clr), .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_grp_idx(o_grp_idx), .o_mv_run(o_mv_run),
    .o_mv_num_cnt(o_mv_num_cnt), .o_mv_base(o_mv_base), .i_mv_idle(i_mv_idle),
    .i_mv_done(i_mv_done), .i_result_0(i_result_0), .i_result_1(i_result_1),
    .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .d_o(d_o)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         exp_wr[$];
  int          exp_base[$];
  int          exp_done = 0;
  int          exp_cnt = 0;
  int          wr_count = 0;
  int          run_count = 0;
  int          done_count = 0;
  logic [31:0] last_wdata = 32'h0;
  bit          mv_enable = 1'b1;
  int          mv_lat = 3;
  int          res0_v = 0;
  int          res1_v = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input longint act);
    tests++;
    fails++;
    $display("FAIL %s: observed 0x%0h with nothing expected at %0t", name, act, $time);
  endtask

  // ReLU then clamp into the signed 16-bit range, as plain integer arithmetic
  function automatic logic [15:0] sat_model(input longint v, input bit relu);
    longint x;
    x = v;
    if (relu && (x < 0)) x = 0;
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
    return x[15:0];
  endfunction

  // Queue up everything one layer should produce
  task automatic expect_layer(input int cnt, input int grp, input int r0, input int r1, input bit relu);
    exp_cnt = cnt;
    if ((cnt != 0) && (grp != 0)) begin
      for (int i = 0; i < grp; i++) begin
        wr_t w;
        w.addr = i;
        w.data = {sat_model(r0, relu), sat_model(r1, relu)};
        exp_base.push_back((i * cnt) % 4096);
        exp_wr.push_back(w);
      end
    end
    exp_done++;
  endtask

  task automatic start_layer(input int cnt, input int grp, input bit relu, input int tmo);
    i_num_cnt = CNT_BIT'(cnt);
    i_num_grp = AWIDTH'(grp);
    i_relu_en = relu;
    i_timeout = TMO_BIT'(tmo);
    i_start   = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!o_idle && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, o_idle, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, o_idle, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_error"}, o_error, 0);
    check({tag, "_grp_idx"}, o_grp_idx, 0);
    check({tag, "_mv_run"}, o_mv_run, 0);
    check({tag, "_mv_cnt"}, o_mv_num_cnt, 0);
    check({tag, "_mv_base"}, o_mv_base, 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_ce"}, ce_o, 0);
    check({tag, "_we"}, we_o, 0);
    check({tag, "_data"}, d_o, 0);
  endtask

  // Mover model: answers each run pulse with one done pulse after mv_lat cycles
  initial begin
    i_mv_done  = 1'b0;
    i_result_0 = '0;
    i_result_1 = '0;
    forever begin
      @(negedge clk);
      if (o_mv_run && mv_enable) begin
        repeat (mv_lat - 1) @(negedge clk);
        i_result_0 = RWIDTH'(res0_v);
        i_result_1 = RWIDTH'(res1_v);
        i_mv_done  = 1'b1;
        @(negedge clk);
        i_mv_done  = 1'b0;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (o_mv_run) begin
        run_count++;
        if (exp_base.size() == 0) flag("unexpected_run", o_mv_base);
        else check("mv_base", o_mv_base, exp_base.pop_front());
      end
      if (we_o) begin
        wr_count++;
        last_wdata = d_o;
        if (exp_wr.size() == 0) begin
          flag("unexpected_write", d_o);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", addr_o, w.addr);
          check("wr_data", d_o, w.data);
        end
      end
      check("ce_we_pair", ce_o, we_o);
      if (o_done) begin
        done_count++;
        if (exp_done == 0) flag("unexpected_done", o_done);
        else exp_done--;
      end
      check("one_status", int'(o_idle) + int'(o_busy) + int'(o_error), 1);
      if (o_busy) check("mv_num_cnt", o_mv_num_cnt, exp_cnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n;
  int          w0;
  int          d0;
  int          sat_r0[6]   = '{70000, 70000, -3, -32768, -32769, -1};
  int          sat_r1[6]   = '{-70000, -70000, 40000, 32767, 32768, 12345};
  bit          sat_relu[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] sat_exp[6]  = '{32'h7FFF8000, 32'h7FFF0000, 32'h00007FFF,
                               32'h80007FFF, 32'h80007FFF, 32'hFFFF3039};

  initial begin
    reset     = 1'b1;
    i_start   = 1'b0;
    i_num_cnt = '0;
    i_num_grp = '0;
    i_relu_en = 1'b0;
    i_timeout = '0;
    i_err_clr = 1'b0;
    i_mv_idle = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic layer: 3 pairs of 4 inputs, results (100,-5)
    res0_v = 100; res1_v = -5; mv_lat = 3;
    w0 = wr_count; d0 = done_count;
    expect_layer(4, 3, 100, -5, 1'b0);
    start_layer(4, 3, 1'b0, 0);
    wait_idle("basic_idle", 200);
    check("basic_wdata", last_wdata, 32'h0064FFFB);
    check("basic_writes", wr_count - w0, 3);
    check("basic_done", done_count - d0, 1);

    // Saturation / ReLU table, single pair, fastest mover
    mv_lat = 1;
    for (int t = 0; t < 6; t++) begin
      res0_v = sat_r0[t]; res1_v = sat_r1[t];
      expect_layer(2, 1, sat_r0[t], sat_r1[t], sat_relu[t]);
      start_layer(2, 1, sat_relu[t], 0);
      if (t == 0) begin
        n = 0;
        while (!we_o && (n < 50)) begin
          @(negedge clk);
          n++;
        end
        check("min_latency", n, 3);
      end
      wait_idle("sat_idle", 100);
      check("sat_wdata", last_wdata, sat_exp[t]);
    end

    // Timeout: mover never answers, limit 10
    mv_enable = 1'b0;
    exp_cnt = 4;
    exp_base.push_back(0);
    w0 = wr_count;
    start_layer(4, 2, 1'b0, 10);
    n = 0;
    while (!o_mv_run && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("tmo_run_seen", o_mv_run, 1);
    n = 0;
    while (!o_error && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 11);
    check("tmo_no_write", wr_count - w0, 0);
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    check("tmo_sticky", o_error, 1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    check("tmo_clr_idle", o_idle, 1);
    check("tmo_clr_error", o_error, 0);
    mv_enable = 1'b1;

    // Zero configuration: done two cycles after start, nothing else
    for (int z = 0; z < 2; z++) begin
      expect_layer((z == 0) ? 5 : 0, (z == 0) ? 0 : 2, 1, 1, 1'b0);
      start_layer((z == 0) ? 5 : 0, (z == 0) ? 0 : 2, 1'b0, 0);
      check("zero_done_early", o_done, 0);
      @(negedge clk);
      check("zero_done_pulse", o_done, 1);
      wait_idle("zero_idle", 10);
    end

    // Mover busy for 5 LAUNCH cycles; a second start mid-layer is ignored
    i_mv_idle = 1'b0;
    mv_lat = 2; res0_v = 7; res1_v = 8;
    w0 = wr_count;
    expect_layer(3, 2, 7, 8, 1'b0);
    start_layer(3, 2, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      check("busy_no_run", o_mv_run, 0);
      if (i < 4) @(negedge clk);
    end
    i_mv_idle = 1'b1;
    @(negedge clk);
    check("busy_run_first_idle", o_mv_run, 1);
    @(negedge clk);
    start_layer(9, 7, 1'b1, 0);
    wait_idle("busy_idle", 200);
    check("busy_writes", wr_count - w0, 2);

    // Reset during WAIT of pair 1 abandons the layer
    mv_lat = 4; res0_v = 1; res1_v = 2;
    expect_layer(5, 3, 1, 2, 1'b0);
    start_layer(5, 3, 1'b0, 0);
    n = 0;
    w0 = 0;
    while ((w0 < 2) && (n < 100)) begin
      @(negedge clk);
      n++;
      if (o_mv_run) w0++;
    end
    check("rstmid_second_run", w0, 2);
    check("rstmid_base1", o_mv_base, 5);
    #1;
    reset = 1'b1;
    exp_wr.delete();
    exp_base.delete();
    exp_done = 0;
    @(negedge clk);
    check_reset_outputs("rstmid");
    reset = 1'b0;
    w0 = wr_count; d0 = done_count;
    repeat (12) @(negedge clk);
    check("rstmid_no_write", wr_count - w0, 0);
    check("rstmid_no_done", done_count - d0, 0);
    check("rstmid_idle", o_idle, 1);

    check("scoreboard_empty", exp_wr.size() + exp_base.size() + exp_done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
